// File: rtl/report_collector.sv
// Tags non-zero report vectors with their symbol offset and queues them for the host; appends a terminator at end of data.
// Latency: a captured report is visible one cycle later. Backpressure: reports are dropped (and counted) when the FIFO is full; the terminator waits for space.
module report_collector #(
    parameter int NUM_REPORTS  = 2,
    parameter int OFFSET_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [NUM_REPORTS-1:0]        report_in,
    input  logic                          end_of_data,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [OFFSET_WIDTH-1:0]       rec_offset,
    output logic [NUM_REPORTS-1:0]        rec_bits,
    output logic                          rec_last,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = OFFSET_WIDTH + NUM_REPORTS + 1;

    typedef enum logic [1:0] {COUNT, TERM, DRAIN, DONE} state_t;

    state_t                  r_state;
    logic [OFFSET_WIDTH-1:0] r_offset;
    logic [RW-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    r_overflow;
    logic [15:0]             r_drop_count;
    logic                    r_done;

    logic                    w_pop;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_rep_req;
    logic                    w_term_req;
    logic                    w_push;
    logic                    w_drop;
    logic [RW-1:0]           w_push_dat;
    logic [RW-1:0]           w_head;

    assign rec_valid  = (r_count != '0);
    assign w_pop      = rec_valid & rec_ready;
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_accept   = ~w_full | w_pop;
    assign w_rep_req  = (r_state == COUNT) & run & (|report_in);
    assign w_term_req = (r_state == TERM);
    assign w_push     = (w_rep_req | w_term_req) & w_accept;
    assign w_drop     = w_rep_req & ~w_accept;
    assign w_push_dat = w_term_req ? {r_offset, NUM_REPORTS'(0), 1'b1}
                                   : {r_offset, report_in, 1'b0};

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign w_head = r_mem[r_rd_ptr];
    assign {rec_offset, rec_bits, rec_last} = rec_valid ? w_head : '0;

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign fifo_level = r_count;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= COUNT;
            r_offset     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
            case (r_state)
                COUNT: begin
                    if (run) begin
                        r_offset <= r_offset + 1'b1;
                    end
                    if (end_of_data) begin
                        r_state <= TERM;
                    end
                end
                TERM: begin
                    if (w_push) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && rec_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: r_state <= COUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_report_collector.sv
// Directed bench for report_collector with a 4-entry FIFO; records are compared as {valid,last,bits,offset}.
module tb_report_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [1:0]  report_in;
    logic        end_of_data;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_offset;
    logic [1:0]  rec_bits;
    logic        rec_last;
    logic        overflow;
    logic [15:0] drop_count;
    logic [2:0]  fifo_level;
    logic        done;

    logic [35:0] rec_obs;
    logic [35:0] exp;
    int          checks   = 0;
    int          failures = 0;

    assign rec_obs = {rec_valid, rec_last, rec_bits, rec_offset};

    always #5 clk = ~clk;

    report_collector #(.NUM_REPORTS(2), .OFFSET_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .run(run), .report_in(report_in),
        .end_of_data(end_of_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_offset(rec_offset), .rec_bits(rec_bits), .rec_last(rec_last),
        .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level),
        .done(done)
    );

    task automatic apply_reset();
        reset = 1'b1; run = 1'b0; report_in = 2'b00; end_of_data = 1'b0; rec_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rec_obs !== 36'd0) begin failures++; $display("FAIL reset_rec: got %h expected %h", rec_obs, 36'd0); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_basic();
        apply_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run = 1'b1;
            report_in = (i == 2 || i == 5) ? 2'b01 : 2'b00;
            @(negedge clk);
            exp = (i == 2 || i == 5) ? {1'b1, 1'b0, 2'b01, 32'(i)} : 36'd0;
            checks++; if (rec_obs !== exp) begin failures++; $display("FAIL basic_rec_at_%0d: got %h expected %h", i, rec_obs, exp); end
        end
        run = 1'b0; report_in = 2'b00; end_of_data = 1'b1;
        @(negedge clk);
        end_of_data = 1'b0;
        checks++; if ({rec_valid, done} !== 2'b00) begin failures++; $display("FAIL basic_term_early: got %b expected 00", {rec_valid, done}); end
        @(negedge clk);
        exp = {1'b1, 1'b1, 2'b00, 32'd8};
        checks++; if (rec_obs !== exp) begin failures++; $display("FAIL basic_term: got %h expected %h", rec_obs, exp); end
        checks++; if ({fifo_level, done} !== {3'd1, 1'b0}) begin failures++; $display("FAIL basic_term_level: got %h expected %h", {fifo_level, done}, {3'd1, 1'b0}); end
        @(negedge clk);
        checks++; if ({rec_valid, done} !== 2'b01) begin failures++; $display("FAIL basic_done: got %b expected 01", {rec_valid, done}); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run = 1'b1; report_in = 2'b10;
            @(negedge clk);
        end
        run = 1'b0; report_in = 2'b00;
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level: got %0d expected 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL bp_drop_count: got %0d expected 2", drop_count); end
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, 1'b0, 2'b10, 32'(k)};
            checks++; if (rec_obs !== exp) begin failures++; $display("FAIL bp_drain_%0d: got %h expected %h", k, rec_obs, exp); end
            @(negedge clk);
        end
        checks++; if ({rec_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b1}) begin failures++; $display("FAIL bp_empty: got %h expected %h", {rec_valid, fifo_level, overflow}, {1'b0, 3'd0, 1'b1}); end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run = 1'b1; report_in = 2'b01;
            @(negedge clk);
        end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_full: got %0d expected 4", fifo_level); end
        run = 1'b1; report_in = 2'b11; rec_ready = 1'b1;
        @(negedge clk);
        run = 1'b0; report_in = 2'b00;
        checks++; if ({fifo_level, overflow, drop_count} !== {3'd4, 1'b0, 16'd0}) begin failures++; $display("FAIL fpp_no_drop: got %h expected %h", {fifo_level, overflow, drop_count}, {3'd4, 1'b0, 16'd0}); end
        for (int k = 1; k < 5; k++) begin
            exp = {1'b1, 1'b0, (k == 4) ? 2'b11 : 2'b01, 32'(k)};
            checks++; if (rec_obs !== exp) begin failures++; $display("FAIL fpp_order_%0d: got %h expected %h", k, rec_obs, exp); end
            @(negedge clk);
        end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL fpp_empty: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_eod_with_report();
        apply_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run = 1'b1;
            report_in = (i == 7) ? 2'b11 : 2'b00;
            end_of_data = (i == 7);
            @(negedge clk);
        end
        exp = {1'b1, 1'b0, 2'b11, 32'd7};
        checks++; if (rec_obs !== exp) begin failures++; $display("FAIL eod_rec: got %h expected %h", rec_obs, exp); end
        end_of_data = 1'b0; run = 1'b1; report_in = 2'b01;
        @(negedge clk);
        exp = {1'b1, 1'b1, 2'b00, 32'd8};
        checks++; if (rec_obs !== exp) begin failures++; $display("FAIL eod_term: got %h expected %h", rec_obs, exp); end
        end_of_data = 1'b1;
        @(negedge clk);
        end_of_data = 1'b0;
        checks++; if ({rec_valid, done} !== 2'b01) begin failures++; $display("FAIL eod_done: got %b expected 01", {rec_valid, done}); end
        @(negedge clk);
        checks++; if ({rec_valid, fifo_level, done, overflow} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL eod_ignored: got %h expected %h", {rec_valid, fifo_level, done, overflow}, {1'b0, 3'd0, 1'b1, 1'b0}); end
        run = 1'b0; report_in = 2'b00;
    endtask

    task automatic test_term_waits();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run = 1'b1; report_in = 2'b01;
            @(negedge clk);
        end
        run = 1'b0; report_in = 2'b00; end_of_data = 1'b1;
        @(negedge clk);
        end_of_data = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({fifo_level, overflow, drop_count, done} !== {3'd4, 1'b0, 16'd0, 1'b0}) begin failures++; $display("FAIL tw_blocked: got %h expected %h", {fifo_level, overflow, drop_count, done}, {3'd4, 1'b0, 16'd0, 1'b0}); end
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, 1'b0, 2'b01, 32'(k)};
            checks++; if (rec_obs !== exp) begin failures++; $display("FAIL tw_drain_%0d: got %h expected %h", k, rec_obs, exp); end
            @(negedge clk);
        end
        exp = {1'b1, 1'b1, 2'b00, 32'd4};
        checks++; if (rec_obs !== exp) begin failures++; $display("FAIL tw_term: got %h expected %h", rec_obs, exp); end
        checks++; if ({overflow, drop_count} !== 17'd0) begin failures++; $display("FAIL tw_no_drop: got %h expected 0", {overflow, drop_count}); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL tw_done: got %b expected 1", done); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            run = 1'b1; report_in = 2'b11;
            @(negedge clk);
        end
        run = 1'b0; report_in = 2'b00;
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL rm_queued: got %0d expected 3", fifo_level); end
        reset = 1'b1; rec_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; rec_ready = 1'b0;
        checks++; if ({rec_obs, fifo_level, overflow, drop_count, done} !== 57'd0) begin failures++; $display("FAIL rm_outputs: got %h expected 0", {rec_obs, fifo_level, overflow, drop_count, done}); end
        run = 1'b1; report_in = 2'b10;
        @(negedge clk);
        run = 1'b0; report_in = 2'b00;
        exp = {1'b1, 1'b0, 2'b10, 32'd0};
        checks++; if (rec_obs !== exp) begin failures++; $display("FAIL rm_first_offset: got %h expected %h", rec_obs, exp); end
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL rm_level: got %0d expected 1", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_push_pop();
        test_eod_with_report();
        test_term_waits();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
